// File: rtl/minpool_seq_ctrl.sv
// Sliding-window min/max pooling sequencer: buffers one IMG x IMG frame, then
// walks each stride-1 WIN x WIN window through a single shared comparator.
module minpool_seq_ctrl #(
  parameter int DW  = 8,
  parameter int IMG = 8,
  parameter int WIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_max,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  localparam int OUT  = IMG - WIN + 1;
  localparam int NPIX = IMG * IMG;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int OW   = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int WW   = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_SCAN, ST_OUT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [OW-1:0] i_reg, i_next, j_reg, j_next;
  logic [WW-1:0] k_reg, k_next, l_reg, l_next;
  logic [DW-1:0] acc_reg, acc_next;
  logic [DW-1:0] out_data_reg, out_data_next;
  logic          out_valid_reg, out_valid_next;
  logic          out_last_reg, out_last_next;
  logic          mode_reg, mode_next;

  logic [DW-1:0] mem [NPIX];
  logic [DW-1:0] rd_data_reg;
  logic [CW-1:0] rd_addr_next;
  logic          wr_en;
  logic          in_fire;
  logic [DW-1:0] cmp_val;
  logic          first_elem;

  assign in_ready   = (state_reg == ST_LOAD) && !rst;
  assign in_fire    = in_valid && in_ready;
  assign busy       = (state_reg != ST_LOAD);
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_last   = out_last_reg;
  assign frame_done = out_valid_reg && out_ready && out_last_reg;

  // rd_data_reg always holds the element addressed by the current (i,j,k,l),
  // because the RAM is read one cycle ahead using the next-state indices.
  assign first_elem = (k_reg == '0) && (l_reg == '0);

  always_comb begin
    cmp_val = acc_reg;
    if (first_elem) begin
      cmp_val = rd_data_reg;
    end else if (mode_reg) begin
      if (rd_data_reg > acc_reg) cmp_val = rd_data_reg;
    end else begin
      if (rd_data_reg < acc_reg) cmp_val = rd_data_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    i_next         = i_reg;
    j_next         = j_reg;
    k_next         = k_reg;
    l_next         = l_reg;
    acc_next       = acc_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    mode_next      = mode_reg;
    wr_en          = 1'b0;

    case (state_reg)
      ST_LOAD: begin
        if (in_fire) begin
          wr_en = 1'b1;
          if (count_reg == '0) mode_next = cfg_max;
          if (count_reg == CW'(NPIX - 1)) begin
            count_next = '0;
            state_next = ST_SCAN;
            i_next     = '0;
            j_next     = '0;
            k_next     = '0;
            l_next     = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end

      ST_SCAN: begin
        acc_next = cmp_val;
        if (l_reg == WW'(WIN - 1)) begin
          l_next = '0;
          if (k_reg == WW'(WIN - 1)) begin
            k_next         = '0;
            state_next     = ST_OUT;
            out_data_next  = cmp_val;
            out_valid_next = 1'b1;
            out_last_next  = (i_reg == OW'(OUT - 1)) && (j_reg == OW'(OUT - 1));
          end else begin
            k_next = k_reg + WW'(1);
          end
        end else begin
          l_next = l_reg + WW'(1);
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          k_next         = '0;
          l_next         = '0;
          if (out_last_reg) begin
            out_last_next = 1'b0;
            state_next    = ST_LOAD;
            i_next        = '0;
            j_next        = '0;
          end else begin
            state_next = ST_SCAN;
            if (j_reg == OW'(OUT - 1)) begin
              j_next = '0;
              i_next = i_reg + OW'(1);
            end else begin
              j_next = j_reg + OW'(1);
            end
          end
        end
      end

      default: state_next = ST_LOAD;
    endcase
  end

  assign rd_addr_next = CW'((int'(i_next) + int'(k_next)) * IMG + int'(j_next) + int'(l_next));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_LOAD;
      count_reg     <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      l_reg         <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      mode_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      i_reg         <= i_next;
      j_reg         <= j_next;
      k_reg         <= k_next;
      l_reg         <= l_next;
      acc_reg       <= acc_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      mode_reg      <= mode_next;
    end
  end

  // Frame buffer; the bypass covers a read of the pixel being written (IMG == 1).
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_reg] <= in_data;
    if (wr_en && (count_reg == rd_addr_next)) rd_data_reg <= in_data;
    else                                       rd_data_reg <= mem[rd_addr_next];
  end

endmodule

// File: tb/tb_minpool_seq_ctrl.sv
// Randomized scoreboard bench for minpool_seq_ctrl: a window-scan reference
// model queues expected results; a negedge monitor pops and compares them.
module tb_minpool_seq_ctrl;
  localparam int DW   = 8;
  localparam int IMG  = 8;
  localparam int WIN  = 3;
  localparam int OUT  = IMG - WIN + 1;
  localparam int NPIX = IMG * IMG;
  localparam int WW2  = WIN * WIN;

  logic          clk = 1'b0;
  logic          rst, cfg_max, in_valid, in_ready, out_valid, out_ready;
  logic          out_last, busy, frame_done;
  logic [DW-1:0] in_data, out_data;

  always #5 clk = ~clk;

  minpool_seq_ctrl #(.DW(DW), .IMG(IMG), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .cfg_max(cfg_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {logic [DW-1:0] d; bit last;} exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int res_cnt = 0, frame_cnt = 0;
  int exp_first_cyc = -1, exp_next_cyc = -1;
  logic [DW-1:0] frm [NPIX];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: scan each output window with plain loops.
  task automatic push_expected(input bit mode);
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < OUT; j++) begin
        exp_t e;
        e.d = frm[i*IMG + j];
        for (int k = 0; k < WIN; k++)
          for (int l = 0; l < WIN; l++) begin
            logic [DW-1:0] v;
            v = frm[(i+k)*IMG + j + l];
            if (mode ? (v > e.d) : (v < e.d)) e.d = v;
          end
        e.last = (i == OUT-1) && (j == OUT-1);
        exp_q.push_back(e);
      end
  endtask

  // Monitor
  exp_t          m_e;
  bit            m_hs, prev_stall = 0, prev_fd = 0, held_last;
  logic [DW-1:0] held_data;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_first_cyc = -1;
      exp_next_cyc  = -1;
      prev_stall    = 0;
      prev_fd       = 0;
    end else begin
      if (prev_fd) check("in_ready_after_done", int'(in_ready), 1);
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(held_data));
        check("hold_last", int'(out_last), int'(held_last));
      end
      if (out_valid && exp_first_cyc >= 0) begin
        check("first_latency", cyc, exp_first_cyc);
        exp_first_cyc = -1;
      end
      if (out_valid && exp_next_cyc >= 0) begin
        check("result_spacing", cyc, exp_next_cyc);
        exp_next_cyc = -1;
      end
      m_hs = out_valid && out_ready;
      if (m_hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d, expected none (cycle %0d)", out_data, cyc);
        end else begin
          m_e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(m_e.d));
          check("out_last", int'(out_last), int'(m_e.last));
          check("frame_done", int'(frame_done), int'(m_e.last));
          if (m_e.last) begin
            frame_cnt++;
            check("in_ready_at_done", int'(in_ready), 0);
          end else begin
            exp_next_cyc = cyc + WW2 + 1;
          end
        end
        res_cnt++;
      end else if (frame_done) begin
        check("spurious_frame_done", int'(frame_done), 0);
      end
      prev_fd    = m_hs && frame_done;
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  task automatic load_frame(input bit mode, input int vprob, input bit toggle);
    int p = 0;
    int guard = 0;
    bit hs;
    push_expected(mode);
    @(posedge clk); #1;
    while (p < NPIX) begin
      in_valid = ($urandom_range(99) < vprob);
      in_data  = frm[p];
      cfg_max  = (p == 0) ? mode : (toggle ? !mode : mode);
      hs = in_valid && in_ready;
      if (hs && p == NPIX-1) exp_first_cyc = cyc + 1 + WW2;
      @(posedge clk); #1;
      if (hs) p++;
      guard++;
      if (guard > 20000) begin
        $display("FAIL load_timeout: got %0d pixels, expected %0d", p, NPIX);
        $fatal(1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(exp_q.size() == 0 && !busy && !out_valid) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) check("idle_timeout", guard, 0);
  endtask

  task automatic wait_results(input int n);
    int guard = 0;
    while (res_cnt < n && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) check("result_wait_timeout", res_cnt, n);
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < NPIX; p++) frm[p] = DW'(p);
  endtask

  int f0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_max = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 255);
    @(posedge clk); #2 rst = 1'b0;
    #1 check("post_rst_in_ready", int'(in_ready), 1);

    // 1: ramp, min
    fill_ramp(); f0 = frame_cnt;
    load_frame(1'b0, 100, 1'b0);
    wait_idle();
    check("s1_frames", frame_cnt, f0 + 1);

    // 2: ramp, max, cfg_max toggled after pixel 0
    f0 = frame_cnt;
    load_frame(1'b1, 100, 1'b1);
    wait_idle();
    check("s2_frames", frame_cnt, f0 + 1);

    // 3: single zero among 200s, min
    for (int p = 0; p < NPIX; p++) frm[p] = 8'd200;
    frm[4*IMG + 4] = 8'd0;
    load_frame(1'b0, 100, 1'b0);
    wait_idle();

    // 4: 50% input gaps and a 5-cycle stall on result #3
    fill_ramp(); res_cnt = 0;
    load_frame(1'b0, 50, 1'b0);
    wait_results(3);
    out_ready = 1'b0;
    for (int g = 0; g < 100 && !out_valid; g++) begin @(posedge clk); #1; end
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // 5: reset during scan of result #10, then a clean ramp frame
    res_cnt = 0;
    load_frame(1'b0, 100, 1'b0);
    wait_results(10);
    repeat (3) @(posedge clk);
    #3;
    check("s5_in_scan", int'(busy && !out_valid), 1);
    rst = 1'b1;
    #1;
    check("s5_rst_out_valid", int'(out_valid), 0);
    check("s5_rst_in_ready", int'(in_ready), 0);
    check("s5_rst_busy", int'(busy), 0);
    @(posedge clk); @(posedge clk); #1;
    check("s5_rst_hold_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1 check("s5_release_in_ready", int'(in_ready), 1);
    f0 = frame_cnt;
    load_frame(1'b0, 100, 1'b0);
    wait_idle();
    check("s5_frames", frame_cnt, f0 + 1);

    // 6: back-to-back ramp min then constant 0x5A max
    f0 = frame_cnt;
    load_frame(1'b0, 100, 1'b0);
    for (int p = 0; p < NPIX; p++) frm[p] = 8'h5A;
    load_frame(1'b1, 100, 1'b0);
    wait_idle();
    check("s6_frames", frame_cnt, f0 + 2);

    // 7: random frames, random mode
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NPIX; p++) frm[p] = DW'($urandom_range(255));
      load_frame(1'($urandom_range(1)), 70, 1'b1);
      wait_idle();
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
